// File: rtl/conway_sequencer.sv
// conway_sequencer: paces load/advance of the Conway cell grid from LOAD/RUN/STEP/STOP commands.
//   clk, rst (async active-low)          clock and reset
//   cmd_valid/cmd_ready/cmd_op           command handshake (00 LOAD, 01 RUN, 10 STEP, 11 STOP)
//   cmd_gens, period, stop_on_still      run parameters captured at RUN/STEP accept
//   grid_changed                         any cell would change on the next generation
//   grid_rst, grid_ena                   shared cell load / advance strobes
//   busy, generation, done, still        status
module conway_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [GEN_W-1:0]    cmd_gens,
    input  logic [PERIOD_W-1:0] period,
    input  logic                stop_on_still,
    input  logic                grid_changed,
    output logic                grid_rst,
    output logic                grid_ena,
    output logic                busy,
    output logic [GEN_W-1:0]    generation,
    output logic                done,
    output logic                still
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, TICK} state_t;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_STEP = 2'b10, OP_STOP = 2'b11;
    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d, period_q, period_d;
    logic [GEN_W-1:0]    remaining_q, remaining_d, gen_d;
    logic                sos_q, sos_d, rst_d, ena_d, done_d, still_d, sched;
    logic                accept;
    assign cmd_ready = state_q != LOAD;
    assign accept    = cmd_valid && cmd_ready;
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        sos_d       = sos_q;
        gen_d       = generation;
        still_d     = still;
        rst_d       = 1'b0;
        ena_d       = 1'b0;
        done_d      = 1'b0;
        sched       = 1'b0;
        case (state_q)
            IDLE: if (accept && cmd_op == OP_LOAD) begin
                state_d = LOAD;
                rst_d   = 1'b1;
            end else if (accept && cmd_op != OP_STOP) begin
                period_d    = (cmd_op == OP_STEP || period == '0) ? PERIOD_W'(1) : period;
                remaining_d = cmd_op == OP_STEP ? GEN_W'(1) : cmd_gens;
                sos_d       = stop_on_still;
                still_d     = 1'b0;
                sched       = 1'b1;
            end
            LOAD: begin
                state_d = IDLE;
                done_d  = 1'b1;
                gen_d   = '0;
                still_d = 1'b0;
            end
            WAIT: if (timer_q == '0) begin
                state_d = TICK;
                ena_d   = !(sos_q && !grid_changed);
            end else begin
                timer_d = timer_q - PERIOD_W'(1);
            end
            TICK: if (!grid_ena) begin
                // suppressed tick: the board was a still life
                state_d = IDLE;
                still_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                gen_d = &generation ? generation : generation + GEN_W'(1);
                // remaining == 0 marks an unbounded run and is never decremented
                if (remaining_q != '0) remaining_d = remaining_q - GEN_W'(1);
                if (remaining_q == GEN_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    sched = 1'b1;
                end
            end
        endcase
        // The WAIT phase is period-1 cycles long; a period of 1 skips it so ticks run back to back
        if (sched) begin
            if (period_d == PERIOD_W'(1)) begin
                state_d = TICK;
                ena_d   = !(sos_d && !grid_changed);
            end else begin
                state_d = WAIT;
                timer_d = period_d - PERIOD_W'(2);
            end
        end
        if (accept && cmd_op == OP_STOP && (state_q == WAIT || state_q == TICK)) begin
            state_d = IDLE;
            ena_d   = 1'b0;
            done_d  = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            period_q    <= '0;
            remaining_q <= '0;
            sos_q       <= 1'b0;
            generation  <= '0;
            still       <= 1'b0;
            grid_rst    <= 1'b0;
            grid_ena    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            sos_q       <= sos_d;
            generation  <= gen_d;
            still       <= still_d;
            grid_rst    <= rst_d;
            grid_ena    <= ena_d;
            done        <= done_d;
            busy        <= state_d != IDLE;
        end
    end
endmodule

// File: tb/tb_conway_sequencer.sv
// tb_conway_sequencer: directed stimulus with a done-driven scoreboard for conway_sequencer.
module tb_conway_sequencer;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_STOP = 2'b11;
    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, stop_on_still, grid_changed;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_gens, period, generation;
    logic        grid_rst, grid_ena, busy, done, still;
    int          cyc = 0;
    int          n_chk = 0, n_fail = 0;
    int          ena_cnt = 0, rst_cnt = 0;
    int          t, u;
    typedef struct {
        int cyc;
        int gen;
        int still;
        int enas;
        int rsts;
    } exp_t;
    exp_t q[$];
    exp_t e;

    conway_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_gens(cmd_gens), .period(period),
        .stop_on_still(stop_on_still), .grid_changed(grid_changed),
        .grid_rst(grid_rst), .grid_ena(grid_ena), .busy(busy),
        .generation(generation), .done(done), .still(still)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_done(input int c, input int g, input int s, input int en, input int rs);
        exp_t x;
        x.cyc = c; x.gen = g; x.still = s; x.enas = en; x.rsts = rs;
        q.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after acceptance with t = accept cycle.
    task automatic send(input logic [1:0] op, input int gens, input int per, input logic sos, output int ta);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_gens = gens[15:0];
        period = per[15:0];
        stop_on_still = sos;
        ta = cyc;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(negedge clk);
            ta = cyc;
        end
        chk("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Check grid_ena each cycle up to 'upto' against ticks at t0+k*p (k<=n, n=0 unbounded).
    task automatic watch(input int t0, input int p, input int n, input int upto);
        int k;
        while (cyc <= upto) begin
            k = cyc - t0;
            chk("grid_ena", grid_ena, k > 0 && k % p == 0 && (n == 0 || k / p <= n));
            @(negedge clk);
        end
    endtask

    // Scoreboard monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            ena_cnt = 0;
            rst_cnt = 0;
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_generation", generation, e.gen);
                    chk("done_still", still, e.still);
                    chk("done_ena_pulses", ena_cnt, e.enas);
                    chk("done_rst_pulses", rst_cnt, e.rsts);
                    chk("done_busy", busy, 0);
                end
                ena_cnt = 0;
                rst_cnt = 0;
            end
            ena_cnt += int'(grid_ena);
            rst_cnt += int'(grid_rst);
        end
    end

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_gens = '0; period = '0;
        stop_on_still = 1'b0; grid_changed = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grid_rst", grid_rst, 0);
        chk("rst_grid_ena", grid_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_still", still, 0);
        chk("rst_generation", generation, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        // LOAD
        expect_done(cyc + 2, 0, 0, 0, 1);
        send(OP_LOAD, 0, 0, 0, t);
        chk("load_grid_rst", grid_rst, 1);
        chk("load_cmd_ready", cmd_ready, 0);
        chk("load_busy", busy, 1);
        @(negedge clk);
        chk("load_grid_rst_end", grid_rst, 0);
        chk("load_busy_end", busy, 0);
        chk("load_cmd_ready_end", cmd_ready, 1);
        @(negedge clk);
        // bounded RUN: 3 generations, period 4
        expect_done(cyc + 13, 3, 0, 3, 0);
        send(OP_RUN, 3, 4, 0, t);
        watch(t, 4, 3, t + 14);
        // unbounded RUN at period 0 (as 1), then STOP
        send(OP_RUN, 0, 0, 0, t);
        watch(t, 1, 0, t + 5);
        expect_done(cyc + 1, 9, 0, 6, 0);
        send(OP_STOP, 0, 0, 0, u);
        chk("stop_ena", grid_ena, 0);
        @(negedge clk);
        chk("stop_ena_after", grid_ena, 0);
        chk("stop_busy", busy, 0);
        @(negedge clk);
        // still-life halt before the third tick
        expect_done(cyc + 7, 11, 1, 2, 0);
        send(OP_RUN, 10, 2, 1, t);
        watch(t, 2, 2, t + 4);
        grid_changed = 1'b0;
        chk("still_wait_ena", grid_ena, 0);
        @(negedge clk);
        chk("still_tick_ena", grid_ena, 0);
        chk("still_tick_busy", busy, 1);
        @(negedge clk);
        chk("still_flag", still, 1);
        grid_changed = 1'b1;
        @(negedge clk);
        // LOAD then two STEPs
        expect_done(cyc + 2, 0, 0, 0, 1);
        send(OP_LOAD, 0, 0, 0, t);
        @(negedge clk);
        expect_done(cyc + 2, 1, 0, 1, 0);
        send(OP_STEP, 5, 7, 0, t);
        chk("step1_ena", grid_ena, 1);
        @(negedge clk);
        expect_done(cyc + 2, 2, 0, 1, 0);
        send(OP_STEP, 5, 7, 0, t);
        chk("step2_ena", grid_ena, 1);
        @(negedge clk);
        chk("step2_generation", generation, 2);
        // RUN issued while busy is dropped
        expect_done(cyc + 11, 4, 0, 2, 0);
        send(OP_RUN, 2, 5, 0, t);
        @(negedge clk);
        send(OP_RUN, 1, 1, 0, u);
        watch(t, 5, 2, t + 12);
        // asynchronous reset in the middle of a run
        send(OP_RUN, 0, 3, 0, t);
        watch(t, 3, 0, t + 5);
        chk("midrun_ena_before", grid_ena, 1);
        rst = 1'b0;
        #1;
        chk("midrun_ena", grid_ena, 0);
        chk("midrun_busy", busy, 0);
        chk("midrun_generation", generation, 0);
        chk("midrun_done", done, 0);
        chk("midrun_grid_rst", grid_rst, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_done(cyc + 2, 0, 0, 0, 1);
        send(OP_LOAD, 0, 0, 0, t);
        chk("reload_grid_rst", grid_rst, 1);
        repeat (4) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
